// File: rtl/ame_det_pipe.sv
// rtl/ame_det_pipe.sv - pipelined multi-lane 2x2 determinant engine (M*D - L*C) with batch control
module ame_det_pipe #(
    parameter int DATA_BITS   = 32,
    parameter int LANES       = 2,
    parameter int PIPE_STAGES = 3,
    parameter int SIGNED      = 1,
    parameter int LEN_BITS    = 16
) (
    input  logic                               clk_i,
    input  logic                               rst_n_i,
    input  logic                               comp_init_i,
    input  logic [LEN_BITS-1:0]                comp_len_i,
    input  logic                               in_valid_i,
    output logic                               in_ready_o,
    input  logic [LANES*4*DATA_BITS-1:0]       in_data_i,
    output logic                               out_valid_o,
    input  logic                               out_ready_i,
    output logic [LANES*(2*DATA_BITS+1)-1:0]   out_data_o,
    output logic                               out_last_o,
    output logic                               comp_busy_o,
    output logic                               comp_done_o
);

    localparam int PW = 2 * DATA_BITS;
    localparam int RW = 2 * DATA_BITS + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [LEN_BITS-1:0] len_q, len_d;
    logic [LEN_BITS-1:0] in_cnt_q, in_cnt_d;
    logic [LEN_BITS-1:0] out_cnt_q, out_cnt_d;
    logic                done_q, done_d;

    logic                adv;
    logic                in_hs;
    logic                out_hs;
    logic                last_beat;

    logic [PIPE_STAGES:1]   vld_q;
    logic [LANES*PW-1:0]    md_c, lc_c;
    logic [LANES*PW-1:0]    md_q, lc_q;
    logic [LANES*RW-1:0]    diff_c;
    logic [LANES*RW-1:0]    dly_q [PIPE_STAGES:2];

    // One global enable: the pipeline moves only when the output slot is free or being taken.
    assign out_valid_o = vld_q[PIPE_STAGES];
    assign adv         = !out_valid_o || out_ready_i;
    assign in_ready_o  = (state_q == ST_RUN) && (in_cnt_q < len_q) && adv;
    assign in_hs       = in_valid_i && in_ready_o;
    assign out_hs      = out_valid_o && out_ready_i;
    assign last_beat   = (out_cnt_q == (len_q - LEN_BITS'(1)));
    assign out_last_o  = out_valid_o && last_beat;
    assign out_data_o  = dly_q[PIPE_STAGES];
    assign comp_busy_o = (state_q != ST_IDLE);
    assign comp_done_o = done_q;

    genvar g;
    for (g = 0; g < LANES; g++) begin : g_lane
        localparam int B = g * 4 * DATA_BITS;

        logic [DATA_BITS-1:0] op_m, op_d, op_l, op_c;
        logic                 s_m, s_d, s_l, s_c;
        logic [PW-1:0]        x_m, x_d, x_l, x_c;
        logic                 e_md, e_lc;

        assign op_c = in_data_i[B               +: DATA_BITS];
        assign op_l = in_data_i[B + DATA_BITS   +: DATA_BITS];
        assign op_d = in_data_i[B + 2*DATA_BITS +: DATA_BITS];
        assign op_m = in_data_i[B + 3*DATA_BITS +: DATA_BITS];

        // Operands are widened to product width first, so the low PW bits of the
        // product are exact for both signed and unsigned interpretations.
        assign s_m = (SIGNED != 0) && op_m[DATA_BITS-1];
        assign s_d = (SIGNED != 0) && op_d[DATA_BITS-1];
        assign s_l = (SIGNED != 0) && op_l[DATA_BITS-1];
        assign s_c = (SIGNED != 0) && op_c[DATA_BITS-1];

        assign x_m = {{DATA_BITS{s_m}}, op_m};
        assign x_d = {{DATA_BITS{s_d}}, op_d};
        assign x_l = {{DATA_BITS{s_l}}, op_l};
        assign x_c = {{DATA_BITS{s_c}}, op_c};

        assign md_c[g*PW +: PW] = x_m * x_d;
        assign lc_c[g*PW +: PW] = x_l * x_c;

        // One extra bit holds the full range of the difference in either mode.
        assign e_md = (SIGNED != 0) && md_q[g*PW + PW - 1];
        assign e_lc = (SIGNED != 0) && lc_q[g*PW + PW - 1];
        assign diff_c[g*RW +: RW] = {e_md, md_q[g*PW +: PW]} - {e_lc, lc_q[g*PW +: PW]};
    end

    // Pipeline registers: data only loads behind a valid beat so the output holds its last value.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            vld_q <= '0;
            md_q  <= '0;
            lc_q  <= '0;
            for (int k = 2; k <= PIPE_STAGES; k++) begin
                dly_q[k] <= '0;
            end
        end else if (adv) begin
            vld_q <= {vld_q[PIPE_STAGES-1:1], in_hs};
            if (in_hs) begin
                md_q <= md_c;
                lc_q <= lc_c;
            end
            if (vld_q[1]) begin
                dly_q[2] <= diff_c;
            end
            for (int k = 3; k <= PIPE_STAGES; k++) begin
                if (vld_q[k-1]) begin
                    dly_q[k] <= dly_q[k-1];
                end
            end
        end
    end

    // Batch control state, length and beat counters.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= ST_IDLE;
            len_q     <= '0;
            in_cnt_q  <= '0;
            out_cnt_q <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            in_cnt_q  <= in_cnt_d;
            out_cnt_q <= out_cnt_d;
            done_q    <= done_d;
        end
    end

    // Next-state: start/ignore init, count handshakes, drain and finish the batch.
    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        in_cnt_d  = in_cnt_q;
        out_cnt_d = out_cnt_q;
        done_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (comp_init_i) begin
                    if (comp_len_i != '0) begin
                        state_d   = ST_RUN;
                        len_d     = comp_len_i;
                        in_cnt_d  = '0;
                        out_cnt_d = '0;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            ST_RUN, ST_DRAIN: begin
                if (in_hs) begin
                    in_cnt_d = in_cnt_q + LEN_BITS'(1);
                end
                if (out_hs) begin
                    out_cnt_d = out_cnt_q + LEN_BITS'(1);
                end
                if ((state_q == ST_RUN) && (in_cnt_d == len_q)) begin
                    state_d = ST_DRAIN;
                end
                if (out_hs && last_beat) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_ame_det_pipe.sv
// tb/tb_ame_det_pipe.sv - scoreboard testbench for ame_det_pipe
module tb_ame_det_pipe;

    localparam int DB = 8;
    localparam int RW = 2*DB + 1;
    localparam int OW = 2*RW;
    localparam int IW = 2*4*DB;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          init;
    logic [15:0]   len;
    logic          in_valid;
    logic          in_ready;
    logic [IW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [OW-1:0] out_data;
    logic          out_last;
    logic          busy;
    logic          done;

    logic          u_init;
    logic [15:0]   u_len;
    logic          u_in_valid;
    logic          u_in_ready;
    logic [IW-1:0] u_in_data;
    logic          u_out_valid;
    logic          u_out_ready;
    logic [OW-1:0] u_out_data;
    logic          u_out_last;
    logic          u_busy;
    logic          u_done;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [OW-1:0] exp_q [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ame_det_pipe #(.DATA_BITS(DB), .LANES(2), .PIPE_STAGES(3), .SIGNED(1), .LEN_BITS(16)) u_dut (
        .clk_i(clk), .rst_n_i(rst_n), .comp_init_i(init), .comp_len_i(len),
        .in_valid_i(in_valid), .in_ready_o(in_ready), .in_data_i(in_data),
        .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data),
        .out_last_o(out_last), .comp_busy_o(busy), .comp_done_o(done)
    );

    ame_det_pipe #(.DATA_BITS(DB), .LANES(2), .PIPE_STAGES(3), .SIGNED(0), .LEN_BITS(16)) u_dut_uns (
        .clk_i(clk), .rst_n_i(rst_n), .comp_init_i(u_init), .comp_len_i(u_len),
        .in_valid_i(u_in_valid), .in_ready_o(u_in_ready), .in_data_i(u_in_data),
        .out_valid_o(u_out_valid), .out_ready_i(u_out_ready), .out_data_o(u_out_data),
        .out_last_o(u_out_last), .comp_busy_o(u_busy), .comp_done_o(u_done)
    );

    function automatic logic [RW-1:0] det_ref(input logic [7:0] m, d, l, c, input bit sgn);
        longint mm, dd, ll, cc;
        mm = sgn ? longint'($signed(m)) : longint'(m);
        dd = sgn ? longint'($signed(d)) : longint'(d);
        ll = sgn ? longint'($signed(l)) : longint'(l);
        cc = sgn ? longint'($signed(c)) : longint'(c);
        return RW'(mm*dd - ll*cc);
    endfunction

    function automatic logic [OW-1:0] model(input logic [IW-1:0] din, input bit sgn);
        logic [OW-1:0] r;
        for (int ln = 0; ln < 2; ln++) begin
            r[ln*RW +: RW] = det_ref(din[ln*32+24 +: 8], din[ln*32+16 +: 8],
                                     din[ln*32+8 +: 8], din[ln*32 +: 8], sgn);
        end
        return r;
    endfunction

    function automatic logic [IW-1:0] pack(input int m0, d0, l0, c0, m1, d1, l1, c1);
        return {8'(m1), 8'(d1), 8'(l1), 8'(c1), 8'(m0), 8'(d0), 8'(l0), 8'(c0)};
    endfunction

    function automatic logic [IW-1:0] rand_beat();
        return {$urandom(), $urandom()};
    endfunction

    task automatic start_batch(input int n);
        init = 1'b1;
        len  = 16'(n);
        @(posedge clk); #1;
        init = 1'b0;
        len  = '0;
    endtask

    task automatic drive_beat(input logic [IW-1:0] din, output bit to, output int acc);
        int n;
        n  = 0;
        to = 1'b0;
        in_valid = 1'b1;
        in_data  = din;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        acc = cyc;
        if (!in_ready) to = 1'b1;
        else exp_q.push_back(model(din, 1'b1));
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({in_ready, out_valid, out_data, out_last, busy, done} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got rdy=%0b vld=%0b data=%h last=%0b busy=%0b done=%0b want all 0",
                     in_ready, out_valid, out_data, out_last, busy, done);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        bit to; int acc; int w;
        logic [OW-1:0] e, lit;
        lit = {17'(-48), 17'(2)};
        start_batch(1);
        fork
            begin
                drive_beat(pack(3, 4, 2, 5, -7, 6, -3, -2), to, acc);
                checks++;
                if (to) begin failures++; $display("FAIL basic_accept got timeout want handshake"); end
            end
            begin
                w = 0;
                @(negedge clk);
                while (!out_valid && w < 100) begin @(negedge clk); w++; end
                checks++;
                if (!out_valid) begin
                    failures++; $display("FAIL basic_out got no valid want valid");
                end else begin
                    e = exp_q.pop_front();
                    checks++;
                    if (out_data !== e || out_data !== lit) begin
                        failures++; $display("FAIL basic_data got %h want %h", out_data, lit);
                    end
                    checks++;
                    if (out_last !== 1'b1) begin failures++; $display("FAIL basic_last got %0b want 1", out_last); end
                    @(negedge clk);
                    checks++;
                    if (done !== 1'b1 || busy !== 1'b0) begin
                        failures++; $display("FAIL basic_done got done=%0b busy=%0b want 1/0", done, busy);
                    end
                    @(negedge clk);
                    checks++;
                    if (done !== 1'b0) begin failures++; $display("FAIL basic_done_pulse got %0b want 0", done); end
                end
            end
        join
        @(posedge clk); #1;
    endtask

    task automatic test_extremes();
        bit to; int acc; int w;
        logic [OW-1:0] e, lit;
        lit = {17'(-32640), 17'(32640)};
        start_batch(2);
        fork
            begin
                drive_beat(pack(-128, -128, -128, 127, -128, 127, -128, -128), to, acc);
                drive_beat(rand_beat(), to, acc);
            end
            begin
                for (int k = 0; k < 2; k++) begin
                    w = 0;
                    @(negedge clk);
                    while (!out_valid && w < 100) begin @(negedge clk); w++; end
                    checks++;
                    if (!out_valid) begin
                        failures++; $display("FAIL extremes_timeout beat=%0d", k);
                        break;
                    end
                    e = exp_q.pop_front();
                    checks++;
                    if (out_data !== e || (k == 0 && out_data !== lit)) begin
                        failures++; $display("FAIL extremes_data beat=%0d got %h want %h", k, out_data, e);
                    end
                    checks++;
                    if (out_last !== (k == 1)) begin
                        failures++; $display("FAIL extremes_last beat=%0d got %0b want %0b", k, out_last, k == 1);
                    end
                end
            end
        join
        repeat (2) @(posedge clk); #1;
    endtask

    task automatic test_unsigned();
        int w;
        logic [IW-1:0] din;
        logic [OW-1:0] lit;
        din = pack(0, 0, 255, 255, 255, 255, 0, 0);
        lit = {17'(65025), 17'(-65025)};
        u_init = 1'b1; u_len = 16'd1;
        @(posedge clk); #1;
        u_init = 1'b0; u_len = '0;
        u_in_valid = 1'b1; u_in_data = din;
        w = 0;
        @(negedge clk);
        while (!u_in_ready && w < 50) begin @(negedge clk); w++; end
        @(posedge clk); #1;
        u_in_valid = 1'b0;
        w = 0;
        @(negedge clk);
        while (!u_out_valid && w < 50) begin @(negedge clk); w++; end
        checks++;
        if (u_out_data !== lit || u_out_data !== model(din, 1'b0) || u_out_last !== 1'b1) begin
            failures++;
            $display("FAIL unsigned_data got %h last=%0b want %h last=1", u_out_data, u_out_last, lit);
        end
        @(negedge clk);
        checks++;
        if (u_done !== 1'b1) begin failures++; $display("FAIL unsigned_done got %0b want 1", u_done); end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        bit to; int acc; int t0; int w;
        logic [OW-1:0] e;
        t0 = 0;
        start_batch(8);
        fork
            begin
                for (int k = 0; k < 8; k++) begin
                    drive_beat(rand_beat(), to, acc);
                    if (k == 0) t0 = acc;
                end
            end
            begin
                for (int k = 0; k < 8; k++) begin
                    w = 0;
                    @(negedge clk);
                    while (!out_valid && w < 100) begin @(negedge clk); w++; end
                    checks++;
                    if (!out_valid) begin failures++; $display("FAIL b2b_timeout beat=%0d", k); break; end
                    e = exp_q.pop_front();
                    checks++;
                    if (cyc !== t0 + 3 + k) begin
                        failures++; $display("FAIL b2b_timing beat=%0d got cycle %0d want %0d", k, cyc, t0 + 3 + k);
                    end
                    checks++;
                    if (out_data !== e) begin failures++; $display("FAIL b2b_data beat=%0d got %h want %h", k, out_data, e); end
                    checks++;
                    if (out_last !== (k == 7) || busy !== 1'b1) begin
                        failures++; $display("FAIL b2b_last_busy beat=%0d got last=%0b busy=%0b want %0b/1", k, out_last, busy, k == 7);
                    end
                end
                @(negedge clk);
                checks++;
                if (done !== 1'b1 || busy !== 1'b0) begin
                    failures++; $display("FAIL b2b_done got done=%0b busy=%0b want 1/0", done, busy);
                end
            end
        join
        @(posedge clk); #1;
    endtask

    task automatic test_stall();
        bit to; int acc; int w;
        logic [OW-1:0] e, snap;
        logic snap_last;
        start_batch(6);
        fork
            begin
                for (int k = 0; k < 6; k++) drive_beat(rand_beat(), to, acc);
            end
            begin
                for (int k = 0; k < 6; k++) begin
                    w = 0;
                    @(negedge clk);
                    while (!(out_valid && out_ready) && w < 100) begin @(negedge clk); w++; end
                    checks++;
                    if (!(out_valid && out_ready)) begin failures++; $display("FAIL stall_timeout beat=%0d", k); break; end
                    e = exp_q.pop_front();
                    checks++;
                    if (out_data !== e || out_last !== (k == 5)) begin
                        failures++; $display("FAIL stall_data beat=%0d got %h last=%0b want %h last=%0b", k, out_data, out_last, e, k == 5);
                    end
                    if (k == 1) begin
                        @(posedge clk); #1;
                        out_ready = 1'b0;
                        for (int s = 0; s < 4; s++) begin
                            @(negedge clk);
                            if (s == 0) begin snap = out_data; snap_last = out_last; end
                            checks++;
                            if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_data !== snap || out_last !== snap_last) begin
                                failures++;
                                $display("FAIL stall_hold cycle=%0d got vld=%0b rdy=%0b data=%h want 1/0/%h", s, out_valid, in_ready, out_data, snap);
                            end
                        end
                        @(posedge clk); #1;
                        out_ready = 1'b1;
                    end
                end
                @(negedge clk);
                checks++;
                if (done !== 1'b1 || exp_q.size() != 0) begin
                    failures++; $display("FAIL stall_done got done=%0b left=%0d want 1/0", done, exp_q.size());
                end
            end
        join
        @(posedge clk); #1;
    endtask

    task automatic test_len0_and_ignore();
        bit to; int acc; int w;
        logic [OW-1:0] e;
        start_batch(0);
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            failures++; $display("FAIL len0_done got done=%0b busy=%0b want 1/0", done, busy);
        end
        for (int s = 0; s < 3; s++) begin
            @(negedge clk);
            checks++;
            if (done !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0) begin
                failures++; $display("FAIL len0_quiet got done=%0b vld=%0b busy=%0b want 0/0/0", done, out_valid, busy);
            end
        end
        @(posedge clk); #1;
        start_batch(4);
        fork
            begin
                drive_beat(rand_beat(), to, acc);
                init = 1'b1; len = 16'd2;
                drive_beat(rand_beat(), to, acc);
                init = 1'b0; len = '0;
                drive_beat(rand_beat(), to, acc);
                drive_beat(rand_beat(), to, acc);
            end
            begin
                for (int k = 0; k < 4; k++) begin
                    w = 0;
                    @(negedge clk);
                    while (!out_valid && w < 100) begin @(negedge clk); w++; end
                    checks++;
                    if (!out_valid) begin failures++; $display("FAIL ignore_timeout beat=%0d", k); break; end
                    e = exp_q.pop_front();
                    checks++;
                    if (out_data !== e || out_last !== (k == 3) || busy !== 1'b1) begin
                        failures++; $display("FAIL ignore_beat beat=%0d got %h last=%0b busy=%0b want %h last=%0b busy=1", k, out_data, out_last, busy, e, k == 3);
                    end
                end
                @(negedge clk);
                checks++;
                if (done !== 1'b1) begin failures++; $display("FAIL ignore_done got %0b want 1", done); end
            end
        join
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        bit to; int acc; int w;
        logic [OW-1:0] e;
        start_batch(8);
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) drive_beat(rand_beat(), to, acc);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || busy !== 1'b1) begin
            failures++; $display("FAIL midrst_pre got vld=%0b busy=%0b want 1/1", out_valid, busy);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({in_ready, out_valid, out_data, out_last, busy, done} !== '0) begin
            failures++;
            $display("FAIL midrst_outputs got rdy=%0b vld=%0b data=%h last=%0b busy=%0b done=%0b want all 0",
                     in_ready, out_valid, out_data, out_last, busy, done);
        end
        exp_q.delete();
        out_ready = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int s = 0; s < 4; s++) begin
            @(negedge clk);
            checks++;
            if (done !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0) begin
                failures++; $display("FAIL midrst_nodone got done=%0b busy=%0b vld=%0b want 0/0/0", done, busy, out_valid);
            end
        end
        @(posedge clk); #1;
        start_batch(2);
        fork
            begin
                for (int k = 0; k < 2; k++) drive_beat(rand_beat(), to, acc);
            end
            begin
                for (int k = 0; k < 2; k++) begin
                    w = 0;
                    @(negedge clk);
                    while (!out_valid && w < 100) begin @(negedge clk); w++; end
                    checks++;
                    if (!out_valid) begin failures++; $display("FAIL postrst_timeout beat=%0d", k); break; end
                    e = exp_q.pop_front();
                    checks++;
                    if (out_data !== e || out_last !== (k == 1)) begin
                        failures++; $display("FAIL postrst_beat beat=%0d got %h last=%0b want %h last=%0b", k, out_data, out_last, e, k == 1);
                    end
                end
                @(negedge clk);
                checks++;
                if (done !== 1'b1) begin failures++; $display("FAIL postrst_done got %0b want 1", done); end
            end
        join
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got no finish want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; init = 1'b0; len = '0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        u_init = 1'b0; u_len = '0; u_in_valid = 1'b0; u_in_data = '0; u_out_ready = 1'b1;
        test_reset();
        test_basic();
        test_extremes();
        test_unsigned();
        test_back_to_back();
        test_stall();
        test_len0_and_ignore();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
